fp_acc_ctrl: RTL and testbench
==============================

Name: fp_acc_ctrl

Overview:
Sequencer that accumulates a stream of IEEE-754 half-precision operands through the shared fixed-latency fpadder in the float_MAC datapath. It pulls operands over a valid/ready stream and drives the adder inputs with (accumulator, operand). It waits out the adder latency, captures the sum back into the accumulator, and after LEN operands presents the result on a valid/ready output. It does no float arithmetic itself; the adder does all of it.

Parameters:
ADD_LAT, 2, rising edges between an add_a/add_b change and a valid add_sum (0 = combinational adder)
LEN_W, 8, width of the len and remaining fields

Ports:
CLK  input  1  system clock, rising edge
RESETn  input  1  reset, asynchronous, active-low
start  input  1  one-cycle start pulse; honoured only in IDLE
len  input  LEN_W  operand count, sampled on accepted start
in_data  input  16  half-precision operand
in_valid  input  1  operand valid
in_ready  output  1  controller accepts operand this cycle
add_a  output  16  to fpadder A (registered)
add_b  output  16  to fpadder B (registered)
add_sum  input  16  from fpadder sum
acc_out  output  16  accumulated result (registered)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
busy  output  1  high in any state except IDLE
remaining  output  LEN_W  operands still to consume

Behaviour:
- Reset is asynchronous and active-low. Outputs go to 0: in_ready, out_valid, busy, add_a, add_b, acc_out, remaining. State goes to IDLE. Reset mid-operation abandons the run; no partial result is emitted.
- IDLE: busy=0, in_ready=0. On start:
  - acc<=16'h0000 and remaining<=len.
  - len!=0: go to FETCH.
  - len==0: go to DONE, so acc_out=0000 and out_valid=1 on the next cycle.
- FETCH: in_ready=1 (combinational from state). On in_valid&&in_ready at edge E0:
  - add_a<=acc and add_b<=in_data.
  - wait counter<=ADD_LAT.
  - go to WAIT.
  - in_valid low: stay in FETCH; add_a/add_b hold.
- WAIT: in_ready=0. The counter decrements each cycle. At edge E0+ADD_LAT+1:
  - acc<=add_sum and remaining<=remaining-1.
  - Go to DONE if remaining was 1, else FETCH.
  - WAIT lasts exactly ADD_LAT+1 cycles, so the minimum is ADD_LAT+2 cycles per operand.
- DONE: out_valid=1, acc_out=acc, both held stable until out_ready. On out_valid&&out_ready go to IDLE and clear out_valid. acc_out keeps its value.
- start outside IDLE is ignored, including in DONE. len changes outside the start cycle are ignored.
- Special values (NaN, Inf, subnormal) pass through untouched; the controller never inspects operands or sums.
- add_a/add_b change only on the FETCH handshake edge. This keeps adder inputs stable for the full latency window.
- remaining wraps never: it goes to DONE at 1 and never decrements from 0.

Test Plan:
Every scenario uses ADD_LAT=2 and a bench fpadder model with 2-edge latency.
1. start, len=3, in_data 3C00,4000,4200 with in_valid held high:
   - (add_a,add_b) sequence is (0000,3C00),(3C00,4000),(4200,4200).
   - out_valid rises 12 cycles after FETCH entry with acc_out=4600.
   - in_ready is high only 1 cycle per operand.
2. start, len=0:
   - out_valid=1 and acc_out=0000 the next cycle.
   - in_ready never asserts and add_a/add_b stay 0000.
3. Backpressure, len=2:
   - in_valid low for 5 cycles in FETCH: controller stays in FETCH, in_ready=1, add_a/add_b unchanged.
   - out_ready low for 4 cycles in DONE: out_valid and acc_out stay stable.
   - Final acc_out=4000 for 3C00+3C00.
4. Second start pulse while busy and again in DONE: both are ignored; remaining and acc_out are unaffected.
5. Assert RESETn=0 mid-WAIT: all outputs go to 0 immediately (asynchronously), without a clock edge. A following run with len=2, 3800,3800 gives acc_out=3C00.
6. Cancellation, len=2, 3C00 then BC00: acc_out=0000 and out_valid=1, then out_ready returns the controller to IDLE with busy=0.

Source files
------------

// File: rtl/fp_acc_ctrl.sv
// fp_acc_ctrl: drives a shared fixed-latency half-precision adder to
// accumulate a stream of LEN operands, then presents the sum on a
// valid/ready output. All float arithmetic happens in the external adder.
module fp_acc_ctrl #(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic [15:0]      acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [LEN_W-1:0] remaining
);

  // Counter must hold ADD_LAT; keep at least one bit for a combinational adder.
  localparam int unsigned CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [15:0]      acc;
  logic [CNT_W-1:0] cnt;

  // Operand acceptance is a direct decode of the FETCH state.
  assign in_ready = (state == S_FETCH);

  // Sequencer: fetch operand, hold adder inputs for the latency window,
  // capture the sum, and repeat until the operand count is exhausted.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= '0;
            remaining <= len;
            busy      <= 1'b1;
            if (len != '0) begin
              state <= S_FETCH;
            end else begin
              // Empty run: report a zero result straight away.
              state     <= S_DONE;
              acc_out   <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            add_a <= acc;
            add_b <= in_data;
            cnt   <= CNT_W'(ADD_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            acc       <= add_sum;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state     <= S_DONE;
              acc_out   <= add_sum;
              out_valid <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_acc_ctrl.sv
// tb_fp_acc_ctrl: directed and randomized runs of fp_acc_ctrl against a
// 2-edge-latency half-precision adder model and a real-valued running sum.
module tb_fp_acc_ctrl;

  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned LEN_W   = 8;

  logic             CLK = 1'b0;
  logic             RESETn;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic [15:0]      add_sum = '0;
  logic [15:0]      sum_p1 = '0;
  logic [15:0]      acc_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [LEN_W-1:0] remaining;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [15:0] ops[$];

  fp_acc_ctrl #(.ADD_LAT(ADD_LAT), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .remaining(remaining)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Half-precision value of a bit pattern, as a real.
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    m = real'(int'(h[9:0]));
    if (e == 0) begin
      e = -24;
    end else begin
      m = m + 1024.0;
      e = e - 25;
    end
    if (e > 0) for (int k = 0; k < e; k++) m = m * 2.0;
    else       for (int k = 0; k < -e; k++) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  // Bit pattern of a real that is exactly representable in half precision.
  function automatic logic [15:0] r2h(input real r);
    logic       s;
    real        a;
    int         e;
    int         m;
    logic [4:0] ex;
    logic [9:0] mn;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0 && e < 40)  begin a = a / 2.0; e++; end
    while (a < 1.0 && e > -40)  begin a = a * 2.0; e--; end
    m  = int'((a - 1.0) * 1024.0);
    ex = 5'(e + 15);
    mn = 10'(m);
    return {s, ex, mn};
  endfunction

  // Stand-in for the shared fpadder: sum valid two rising edges after inputs change.
  always @(posedge CLK) begin
    sum_p1  <= r2h(h2r(add_a) + h2r(add_b));
    add_sum <= sum_p1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full run over the operands in ops, with optional backpressure and stray start pulses.
  task automatic do_run(input int in_stall, input int out_stall, input bit hold_valid, input bit poke);
    real         sum;
    logic [15:0] acc_h, prev_a, prev_b, res;
    int          n, cnt, t0;
    n      = ops.size();
    sum    = 0.0;
    acc_h  = 16'h0000;
    prev_a = add_a;
    prev_b = add_b;
    start  = 1'b1;
    len    = LEN_W'(n);
    tick();
    start  = 1'b0;
    len    = LEN_W'($urandom);
    t0     = cyc;
    chk("busy_after_start", busy, 1);
    chk("remaining_after_start", remaining, (n == 0) ? 0 : n);
    if (n == 0) begin
      chk("len0_in_ready", in_ready, 0);
      chk("len0_add_a", add_a, prev_a);
      chk("len0_add_b", add_b, prev_b);
    end
    for (int i = 0; i < n; i++) begin
      chk("fetch_in_ready", in_ready, 1);
      prev_a = add_a;
      prev_b = add_b;
      for (int s = 0; s < in_stall; s++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick();
        chk("stall_in_ready", in_ready, 1);
        chk("stall_add_a", add_a, prev_a);
        chk("stall_add_b", add_b, prev_b);
      end
      in_data  = ops[i];
      in_valid = 1'b1;
      tick();
      chk("add_a", add_a, acc_h);
      chk("add_b", add_b, ops[i]);
      chk("wait_in_ready", in_ready, 0);
      if (poke && i == 0) begin
        start = 1'b1;
        len   = LEN_W'(5);
      end
      if (!hold_valid) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else if (i + 1 < n) begin
        in_data = ops[i + 1];
      end
      cnt = 0;
      while (!(in_ready || out_valid) && cnt < 20) begin
        tick();
        start = 1'b0;
        cnt++;
      end
      start = 1'b0;
      chk("wait_cycles", cnt, ADD_LAT + 1);
      sum   = sum + h2r(ops[i]);
      acc_h = r2h(sum);
      chk("remaining", remaining, n - i - 1);
    end
    in_valid = 1'b0;
    res = r2h(sum);
    chk("done_out_valid", out_valid, 1);
    chk("done_acc_out", acc_out, res);
    chk("done_busy", busy, 1);
    chk("done_remaining", remaining, 0);
    if (n > 0) chk("fetch_to_done_cycles", cyc - t0, n * (ADD_LAT + 2 + in_stall));
    out_ready = 1'b0;
    for (int s = 0; s < out_stall; s++) begin
      if (poke && s == 0) begin
        start = 1'b1;
        len   = LEN_W'(7);
      end
      tick();
      start = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_acc_out", acc_out, res);
      chk("hold_remaining", remaining, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_acc_out", acc_out, res);
    chk("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESETn    = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_remaining", remaining, 0);
    RESETn = 1'b1;
    tick();

    // len = 0: immediate zero result, adder inputs untouched.
    ops.delete();
    do_run(0, 0, 0, 0);
    chk("t2_acc_out", acc_out, 16'h0000);
    chk("t2_add_a", add_a, 16'h0000);

    // 1 + 2 + 3 with in_valid held high.
    ops = '{16'h3C00, 16'h4000, 16'h4200};
    do_run(0, 0, 1, 0);
    chk("t1_acc_out", acc_out, 16'h4600);
    chk("t1_last_add_a", add_a, 16'h4200);

    // Input and output backpressure.
    ops = '{16'h3C00, 16'h3C00};
    do_run(5, 4, 0, 0);
    chk("t3_acc_out", acc_out, 16'h4000);

    // Stray start pulses while busy and in DONE.
    ops = '{16'h4000, 16'h4000, 16'h3C00};
    do_run(0, 3, 0, 1);
    chk("t4_acc_out", acc_out, 16'h4500);

    // Asynchronous reset in the middle of WAIT.
    start = 1'b1;
    len   = LEN_W'(2);
    tick();
    start    = 1'b0;
    in_data  = 16'h3C00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_add_a", add_a, 0);
    chk("arst_add_b", add_b, 0);
    chk("arst_acc_out", acc_out, 0);
    chk("arst_remaining", remaining, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    tick();
    chk("arst_no_result", out_valid, 0);
    ops = '{16'h3800, 16'h3800};
    do_run(0, 0, 0, 0);
    chk("t5_acc_out", acc_out, 16'h3C00);

    // Cancellation to zero.
    ops = '{16'h3C00, 16'hBC00};
    do_run(0, 1, 0, 0);
    chk("t6_acc_out", acc_out, 16'h0000);

    // Randomized runs against the real-valued running sum.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 6);
      ops.delete();
      for (int k = 0; k < n; k++) begin
        int v;
        v = $urandom_range(0, 64);
        ops.push_back(r2h(real'(v - 32) / 2.0));
      end
      do_run($urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
